// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
`default_nettype none

package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch entries with push/pop/flush.
`default_nettype none

module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  fetch_entry_t               i_data,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW:0]    r_wr;
  logic [AW:0]    r_rd;

  // Extra MSB on each pointer lets wr - rd reach DEPTH without aliasing to empty.
  assign o_count = r_wr - r_rd;
  assign o_head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (i_pop) begin
        r_rd <= r_rd + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ifetch: PC owner, imem request side and decoupling FIFO toward decode.
// Optional misaligned-redirect trap marker enabled by IFETCH_MISALIGN_TRAP_EN.
`default_nettype none

module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [31:0]  r_fetch_pc;
  logic [AW:0]  w_count;
  logic         w_pop;
  logic         w_push;
  logic         w_advance;
  logic         w_halted;
  logic         w_marker;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  assign imem_pc   = r_fetch_pc;
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = ~redirect_valid & ~w_halted & ((w_count < DEPTH_CNT) | w_pop);
  // The marker push reuses the fetch slot but must not step the PC.
  assign w_advance = w_push & ~w_marker;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic       r_halted;
  logic [1:0] r_mis_lo;

  assign w_halted = r_halted;
  assign w_marker = (r_mis_lo != 2'b00);
  assign w_entry  = w_marker ? '{pc: {r_fetch_pc[31:2], r_mis_lo}, inst: NOP_INST, misalign: 1'b1}
                             : '{pc: r_fetch_pc, inst: imem_inst, misalign: 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
      r_mis_lo <= 2'b00;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
      r_mis_lo <= redirect_pc[1:0];
    end else if (w_push && w_marker) begin
      r_halted <= 1'b1;
      r_mis_lo <= 2'b00;
    end
  end
`else
  assign w_halted = 1'b0;
  assign w_marker = 1'b0;
  assign w_entry  = '{pc: r_fetch_pc, inst: imem_inst, misalign: 1'b0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~32'h3;
    end else if (w_advance) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop & ~redirect_valid),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_pc       = w_head.pc;
  assign out_inst     = w_head.inst;
  assign out_misalign = w_head.misalign;

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch (default and high RESET_PC instances).
`default_nettype none

module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;

  logic        rst_b_n;
  logic [31:0] b_imem_pc;
  logic [31:0] b_imem_inst;
  logic        b_out_valid;
  logic [31:0] b_out_pc;
  logic [31:0] b_out_inst;
  logic        b_out_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory word at index i is 0x1000_0000 + i.
  assign imem_inst   = 32'h1000_0000 + {2'b00, imem_pc[31:2]};
  assign b_imem_inst = 32'h1000_0000 + {2'b00, b_imem_pc[31:2]};

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misalign   (out_misalign)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
    .clk            (clk),
    .rst_n          (rst_b_n),
    .imem_pc        (b_imem_pc),
    .imem_inst      (b_imem_inst),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (b_out_valid),
    .out_ready      (1'b1),
    .out_pc         (b_out_pc),
    .out_inst       (b_out_inst),
    .out_misalign   (b_out_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, 32'h1000_0000 + {2'b00, pc[31:2]});
  endtask

  initial begin
    rst_n          = 1'b0;
    rst_b_n        = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) step();

    // Reset state
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_mis", {31'b0, out_misalign}, 32'h0);
    check("rst_imem_pc", imem_pc, 32'h0);
    check("rst_b_imem_pc", b_imem_pc, 32'hFFFF_FFF8);

    // Streaming, one per cycle, first valid one edge after release
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_head($sformatf("stream%0d", i), 1'b1, 32'(i * 4));
    end

    // Stall after 1 entry: count saturates at 2, PC holds at 8
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step();
    check_head("stall_first", 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_imem_pc", imem_pc, 32'h8);
      check("stall_head_pc", out_pc, 32'h0);
    end
    out_ready = 1'b1;
    step();
    check_head("drain0", 1'b1, 32'h4);
    step();
    check_head("drain1", 1'b1, 32'h8);
    step();
    check_head("drain2", 1'b1, 32'hC);

    // Redirect with full FIFO and consumer ready
    out_ready = 1'b0;
    step();
    step();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    check("redir_bubble", {31'b0, out_valid}, 32'h0);
    check("redir_imem_pc", imem_pc, 32'h400);
    step();
    check_head("redir_tgt", 1'b1, 32'h400);
    step();
    check_head("redir_next", 1'b1, 32'h404);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    check("mis_bubble", {31'b0, out_valid}, 32'h0);
    check("mis_imem_pc", imem_pc, 32'h100);
    step();
    check("mis_valid", {31'b0, out_valid}, 32'h1);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis_pc", out_pc, 32'h102);
    check("mis_inst", out_inst, 32'h13);
    check("mis_flag", {31'b0, out_misalign}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mis_halt_valid", {31'b0, out_valid}, 32'h0);
      check("mis_halt_pc", imem_pc, 32'h100);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    step();
    check_head("mis_resume", 1'b1, 32'h200);
`else
    check("mis_pc", out_pc, 32'h100);
    check("mis_inst", out_inst, 32'h1000_0040);
    check("mis_flag", {31'b0, out_misalign}, 32'h0);
    step();
    check_head("mis_next", 1'b1, 32'h104);
`endif

    // Asynchronous reset mid-stream with 2 entries held
    out_ready = 1'b0;
    step();
    step();
    check("areset_pre_valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", {31'b0, out_valid}, 32'h0);
    check("areset_imem_pc", imem_pc, 32'h0);
    check("areset_pc", out_pc, 32'h0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check_head("areset_restart", 1'b1, 32'h0);

    // High RESET_PC wraps through zero
    rst_b_n = 1'b1;
    step();
    check("wrap0", b_out_pc, 32'hFFFF_FFF8);
    step();
    check("wrap1", b_out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap2", b_out_pc, 32'h0000_0000);
    check("wrap2_inst", b_out_inst, 32'h1000_0000);
    check("wrap2_valid", {31'b0, b_out_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the requesting side of the instruction memory port. It owns the program counter, drives the fetch address to the combinational-read instruction memory, and captures each returned word with its PC into a small FIFO. Decode drains that FIFO through a valid/ready handshake. A redirect from execute (branch, jump or trap) flushes the FIFO and restarts fetch at a new PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 2, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_pc  out  32  fetch address to instruction memory; memory indexes imem_pc[31:2]
- imem_inst  in  32  instruction word for imem_pc, valid in the same cycle (combinational read)
- redirect_valid  in  1  restart fetch at redirect_pc this cycle
- redirect_pc  in  32  new fetch PC
- out_valid  out  1  FIFO head holds an instruction
- out_ready  in  1  decode accepts the head this cycle
- out_pc  out  32  PC of head entry
- out_inst  out  32  instruction of head entry
- out_misalign  out  1  head entry is a misaligned-fetch marker (see Configuration)

## Operation
- State: fetch_pc register, FIFO of {pc, inst, misalign}, halted flag (macro build only).
- imem_pc = fetch_pc, driven combinationally.
- pop = out_valid & out_ready.
- push = !redirect_valid & !halted & (count < DEPTH | pop).
  - On push: entry {fetch_pc, imem_inst, 0} is written; fetch_pc <= fetch_pc + 4.
  - The add is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0.
- Full FIFO with pop in the same cycle: pop and push both happen and count is unchanged.
- Empty FIFO: no pop is possible; push proceeds.
- Redirect has priority over push and pop:
  - FIFO is flushed (count <= 0) and any pop that cycle is discarded.
  - fetch_pc <= redirect_pc & ~32'h3.
  - halted <= 0.
- out_pc, out_inst and out_misalign always show the head storage slot, even when out_valid is 0.
- Reset values: fetch_pc = RESET_PC, count = 0, read/write pointers = 0, all storage = 0, halted = 0.
  - Resulting outputs: out_valid 0, out_pc 0, out_inst 0, out_misalign 0, imem_pc RESET_PC.
- Reset asserted mid-stream drops all entries immediately (asynchronous).

## Timing
- Fetch-to-output latency: an entry pushed at edge N is visible with out_valid = 1 after edge N.
- Redirect sampled at edge N:
  - out_valid = 0 after edge N.
  - imem_pc = redirect target after edge N.
  - The target instruction appears after edge N+1.
  - Redirect bubble is therefore 1 cycle.
- Steady-state throughput is 1 instruction/cycle while out_ready stays high.
- A stalled consumer (out_ready = 0) causes fetch to stop once count = DEPTH. fetch_pc holds, and entries and order are preserved.
- Back-to-back redirects: the last one wins; each one flushes the FIFO.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0] != 0 behaves as follows.
  - Next cycle a single marker entry is pushed: {redirect_pc unmasked, 32'h0000_0013 (NOP), misalign = 1}.
  - halted is then set: no further pushes until the next redirect.
  - Back-pressure on the marker follows the normal push rules.
- IFETCH_MISALIGN_TRAP_EN undefined: low PC bits are silently masked, out_misalign is tied 0, and no halted logic exists.

## Structure
- Package ifetch_pkg holds:
  - fetch_entry_t struct {pc[31:0], inst[31:0], misalign}
  - NOP_INST = 32'h0000_0013
  - default RESET_PC
- Sub-module ifetch_fifo: a synchronous FIFO of fetch_entry_t, parameterized by DEPTH.
  - Interface: push/pop/flush, count, head output.
  - Pointers carry an extra wrap bit to distinguish full from empty.
- Top level holds fetch_pc, the push/redirect control and the misalignment logic.

## Test plan
- Reset, out_ready = 1, memory word i = 32'h1000_0000 + i: out_pc steps 0, 4, 8… with matching inst, 1/cycle, and first out_valid appears 1 cycle after reset release.
- out_ready = 0 for 5 cycles after 1 entry, DEPTH = 2: count saturates at 2 and imem_pc holds at 8. Releasing out_ready yields PCs 0, 4, 8 in order, with no loss and no duplicates.
- Redirect to 32'h0000_0400 while the FIFO is full and out_ready = 1: the head is not consumed, out_valid = 0 for 1 cycle, and the next out_pc is 32'h400.
- RESET_PC = 32'hFFFF_FFF8: out_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With the macro, redirect to 32'h0000_0102: one entry with out_pc 32'h102, out_inst 32'h13, out_misalign 1, then out_valid stays 0 until a redirect to 32'h200 resumes fetch. Without the macro the same stimulus gives out_pc 32'h100 and out_misalign 0.
- rst_n pulled low mid-stream with 2 entries: out_valid drops immediately, without waiting for clk. After release, fetch restarts at RESET_PC.
